// File: rtl/ray_sched_rr.sv
// ray_sched_rr: round-robin scheduler sharing one triangle-intersection batch
// engine between N_REQ ray requesters. Each accepted request is launched on
// the engine (unless its triangle count is zero). The engine result is then
// held on the shared response bus until the owning requester accepts it.
module ray_sched_rr #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [31:0]          i_baseaddr,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ*192-1:0] i_req_ray,
  input  logic [N_REQ*32-1:0]  i_req_tri_cnt,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic [N_REQ-1:0]     o_resp_valid,
  input  logic [N_REQ-1:0]     i_resp_ready,
  output logic                 o_resp_hit,
  output logic [31:0]          o_resp_t,
  output logic [31:0]          o_resp_tri_index,
  output logic                 o_eng_start,
  output logic [31:0]          o_eng_baseaddr,
  output logic [191:0]         o_eng_ray,
  output logic [31:0]          o_eng_tri_cnt,
  input  logic                 i_eng_hit,
  input  logic [31:0]          i_eng_t,
  input  logic [31:0]          i_eng_tri_index,
  input  logic                 i_eng_finish,
  output logic                 o_busy,
  output logic [15:0]          o_batches
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Result reported for an empty triangle list: no hit, "infinite" distance.
  localparam logic [31:0] T_NO_HIT = 32'h7FFF_FFFF;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [191:0]       ray_reg;
  logic [31:0]        tri_cnt_reg;
  logic               hit_reg;
  logic [31:0]        t_reg;
  logic [31:0]        idx_reg;
  logic [15:0]        batches_reg;

  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   grant_next_ptr;
  logic [191:0]       grant_ray;
  logic [31:0]        grant_cnt;
  logic               handshake;

  logic [191:0]       req_ray_arr [N_REQ];
  logic [31:0]        req_cnt_arr [N_REQ];

  // Unpack the flat per-requester buses and build the one-hot ready/valid.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_ray_arr[gi]  = i_req_ray[192*gi +: 192];
    assign req_cnt_arr[gi]  = i_req_tri_cnt[32*gi +: 32];
    // Ready is gated by reset so no handshake can happen in a reset cycle.
    assign o_req_ready[gi]  = i_rstn && (state_reg == S_IDLE) && grant_any &&
                              (grant_idx == IDX_W'(gi));
    assign o_resp_valid[gi] = (state_reg == S_RESP) && (owner_reg == IDX_W'(gi));
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (i_req_valid[cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Pointer to the requester after the winner, plus the winner's payload.
  always_comb begin
    if (grant_idx == IDX_W'(N_REQ - 1)) begin
      grant_next_ptr = '0;
    end else begin
      grant_next_ptr = grant_idx + IDX_W'(1);
    end
    grant_ray = req_ray_arr[grant_idx];
    grant_cnt = req_cnt_arr[grant_idx];
    handshake = (state_reg == S_IDLE) && grant_any;
  end

  // Scheduler FSM: accept, launch, let the stale finish level clear, wait,
  // then hold the response until the owner takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_reg   <= S_IDLE;
      rr_ptr_reg  <= '0;
      owner_reg   <= '0;
      ray_reg     <= '0;
      tri_cnt_reg <= '0;
      hit_reg     <= 1'b0;
      t_reg       <= '0;
      idx_reg     <= '0;
      batches_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (handshake) begin
            owner_reg   <= grant_idx;
            rr_ptr_reg  <= grant_next_ptr;
            ray_reg     <= grant_ray;
            tri_cnt_reg <= grant_cnt;
            if (grant_cnt == '0) begin
              // Empty triangle list: answer directly, the engine is not used.
              hit_reg   <= 1'b0;
              t_reg     <= T_NO_HIT;
              idx_reg   <= '0;
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          state_reg <= S_SETTLE;
        end
        S_SETTLE: begin
          // Finish still shows the previous batch's level here; ignore it.
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (i_eng_finish) begin
            hit_reg   <= i_eng_hit;
            t_reg     <= i_eng_t;
            idx_reg   <= i_eng_tri_index;
            state_reg <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_resp_ready[owner_reg]) begin
            if (batches_reg != 16'hFFFF) begin
              batches_reg <= batches_reg + 16'd1;
            end
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Output mapping from the registered state.
  always_comb begin
    o_eng_start      = (state_reg == S_LAUNCH);
    o_eng_baseaddr   = i_baseaddr;
    o_eng_ray        = ray_reg;
    o_eng_tri_cnt    = tri_cnt_reg;
    o_resp_hit       = hit_reg;
    o_resp_t         = t_reg;
    o_resp_tri_index = idx_reg;
    o_busy           = (state_reg != S_IDLE);
    o_batches        = batches_reg;
  end

endmodule
